// File: rtl/prbs_pkg.sv
// Shared definitions for the PRBS generator/checker pair: FSM encodings,
// default polynomial constants and the common LFSR next-state function.
package prbs_pkg;

    localparam int unsigned MAX_W          = 32;
    localparam int unsigned DEF_WIDTH      = 8;
    localparam logic [7:0]  DEF_TAPS       = 8'hB8;
    localparam int unsigned DEF_LOCK_CNT   = 4;
    localparam int unsigned DEF_UNLOCK_CNT = 3;
    localparam int unsigned DEF_CNT_W      = 16;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        LOCKED = 2'd1,
        LOST   = 2'd2
    } state_t;

    // Fibonacci LFSR step for any width up to MAX_W: shift left, feed parity of tapped bits into bit 0.
    function automatic logic [MAX_W-1:0] lfsr_next(input logic [MAX_W-1:0] cur,
                                                   input logic [MAX_W-1:0] taps,
                                                   input int unsigned      width);
        logic [MAX_W-1:0] mask;
        mask = (width >= MAX_W) ? '1 : ((MAX_W'(1) << width) - MAX_W'(1));
        return {cur[MAX_W-2:0], ^(cur & taps & mask)} & mask;
    endfunction

endpackage

// File: rtl/prbs_checker_lfsr_predict.sv
// Combinational LFSR next-word predictor used by the checker.
module lfsr_predict
    import prbs_pkg::*;
#(
    parameter int unsigned      WIDTH = DEF_WIDTH,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(DEF_TAPS)
) (
    input  logic [WIDTH-1:0] cur,
    output logic [WIDTH-1:0] nxt
);

    assign nxt = WIDTH'(lfsr_next(MAX_W'(cur), MAX_W'(TAPS), WIDTH));

endmodule

// File: rtl/prbs_checker.sv
// PRBS checker: self-synchronises to an incoming LFSR sequence, then flags
// and counts words that deviate from the free-running local prediction.
module prbs_checker
    import prbs_pkg::*;
#(
    parameter int unsigned      WIDTH      = DEF_WIDTH,
    parameter logic [WIDTH-1:0] TAPS       = WIDTH'(DEF_TAPS),
    parameter int unsigned      LOCK_CNT   = DEF_LOCK_CNT,
    parameter int unsigned      UNLOCK_CNT = DEF_UNLOCK_CNT,
    parameter int unsigned      CNT_W      = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             clear_counts,
    output logic             locked,
    output logic             error,
    output logic [CNT_W-1:0] err_count,
    output logic [1:0]       state_dbg
);

    localparam logic [3:0] LOCK_C   = LOCK_CNT[3:0];
    localparam logic [3:0] UNLOCK_C = UNLOCK_CNT[3:0];

    state_t           state, state_nx;
    logic [WIDTH-1:0] expected, expected_nx;
    logic [WIDTH-1:0] pred_in, pred;
    logic [3:0]       match_run, match_nx;
    logic [3:0]       miss_run, miss_nx;
    logic             err_nx;

    // Search reseeds from the incoming word; locked mode free-runs on its own prediction.
    assign pred_in = (state == LOCKED) ? expected : din;

    lfsr_predict #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS)
    ) u_predict (
        .cur (pred_in),
        .nxt (pred)
    );

    always_comb begin
        state_nx    = state;
        expected_nx = expected;
        match_nx    = match_run;
        miss_nx     = miss_run;
        err_nx      = 1'b0;
        if (din_valid) begin
            case (state)
                SEARCH: begin
                    expected_nx = pred;
                    if (din == expected && din != '0) begin
                        if (match_run + 4'd1 == LOCK_C) begin
                            state_nx = LOCKED;
                            match_nx = '0;
                            miss_nx  = '0;
                        end else begin
                            match_nx = match_run + 4'd1;
                        end
                    end else begin
                        match_nx = '0;
                    end
                end
                LOCKED: begin
                    expected_nx = pred;
                    if (din != expected) begin
                        err_nx = 1'b1;
                        if (miss_run + 4'd1 == UNLOCK_C) begin
                            state_nx = LOST;
                            miss_nx  = '0;
                            match_nx = '0;
                        end else begin
                            miss_nx = miss_run + 4'd1;
                        end
                    end else begin
                        miss_nx = '0;
                    end
                end
                LOST: begin
                    expected_nx = pred;
                    state_nx    = SEARCH;
                    match_nx    = '0;
                    miss_nx     = '0;
                end
                default: begin
                    state_nx = SEARCH;
                    match_nx = '0;
                    miss_nx  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= SEARCH;
            expected  <= '0;
            match_run <= '0;
            miss_run  <= '0;
            locked    <= 1'b0;
            error     <= 1'b0;
            err_count <= '0;
        end else begin
            state     <= state_nx;
            expected  <= expected_nx;
            match_run <= match_nx;
            miss_run  <= miss_nx;
            locked    <= (state_nx == LOCKED);
            error     <= err_nx;
            if (clear_counts) begin
                err_count <= '0;
            end else if (err_nx && err_count != '1) begin
                err_count <= err_count + CNT_W'(1);
            end
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_prbs_checker.sv
// Randomised self-checking bench for prbs_checker against a sequence-level
// reference model; runs a 16-bit and a 4-bit error-counter instance in parallel.
module tb_prbs_checker;

    localparam logic [7:0] TB_TAPS = 8'hB8;
    localparam int LOCK_N   = 4;
    localparam int UNLOCK_N = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  din = '0;
    logic        din_valid = 1'b0;
    logic        clear_counts = 1'b0;

    logic        locked_a, error_a, locked_b, error_b;
    logic [15:0] err_count_a;
    logic [3:0]  err_count_b;
    logic [1:0]  state_dbg_a, state_dbg_b;

    int n_cmp = 0;
    int n_bad = 0;

    prbs_checker dut (
        .clk          (clk),
        .reset        (reset),
        .din          (din),
        .din_valid    (din_valid),
        .clear_counts (clear_counts),
        .locked       (locked_a),
        .error        (error_a),
        .err_count    (err_count_a),
        .state_dbg    (state_dbg_a)
    );

    prbs_checker #(.CNT_W(4)) dut4 (
        .clk          (clk),
        .reset        (reset),
        .din          (din),
        .din_valid    (din_valid),
        .clear_counts (clear_counts),
        .locked       (locked_b),
        .error        (error_b),
        .err_count    (err_count_b),
        .state_dbg    (state_dbg_b)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] tbnext(input logic [7:0] c);
        int p;
        p = 0;
        for (int i = 0; i < 8; i++) if (TB_TAPS[i]) p = p ^ int'(c[i]);
        return {c[6:0], p[0]};
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: mode 0=searching, 1=locked, 2=lost.
    int         m_mode, m_run, m_miss, m_cnt16, m_cnt4;
    bit         m_have_prev, m_err;
    logic [7:0] m_prev, m_pred;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_mode = 0; m_run = 0; m_miss = 0; m_cnt16 = 0; m_cnt4 = 0;
            m_have_prev = 0; m_err = 0; m_prev = '0; m_pred = '0;
        end else begin
            m_err = 0;
            if (din_valid) begin
                if (m_mode == 0) begin
                    if (m_have_prev && din == tbnext(m_prev) && din != 8'h00) m_run++;
                    else m_run = 0;
                    m_prev = din;
                    m_have_prev = 1;
                    if (m_run == LOCK_N) begin
                        m_mode = 1; m_run = 0; m_miss = 0; m_pred = tbnext(din);
                    end
                end else if (m_mode == 1) begin
                    if (din != m_pred) begin m_err = 1; m_miss++; end
                    else m_miss = 0;
                    m_pred = tbnext(m_pred);
                    if (m_miss == UNLOCK_N) m_mode = 2;
                end else begin
                    m_prev = din; m_have_prev = 1; m_run = 0; m_mode = 0;
                end
            end
            if (clear_counts) begin
                m_cnt16 = 0; m_cnt4 = 0;
            end else if (m_err) begin
                if (m_cnt16 < 65535) m_cnt16++;
                if (m_cnt4 < 15) m_cnt4++;
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            chk("locked",      locked_a,    m_mode == 1);
            chk("error",       error_a,     m_err);
            chk("err_count16", err_count_a, m_cnt16);
            chk("state_dbg",   state_dbg_a, m_mode);
            chk("locked4",     locked_b,    m_mode == 1);
            chk("err_count4",  err_count_b, m_cnt4);
        end
    end

    logic [7:0] gen;

    task automatic drive(input logic [7:0] w, input logic v, input logic clr);
        din = w; din_valid = v; clear_counts = clr;
        @(posedge clk);
        #1;
        din_valid = 1'b0; clear_counts = 1'b0;
    endtask

    task automatic good(input logic clr);
        gen = tbnext(gen);
        drive(gen, 1'b1, clr);
    endtask

    task automatic bad(input logic clr);
        gen = tbnext(gen);
        drive(gen ^ 8'h01, 1'b1, clr);
    endtask

    initial begin
        chk("model next 01", tbnext(8'h01), 8'h02);
        chk("model next 08", tbnext(8'h08), 8'h11);
        chk("model next 11", tbnext(8'h11), 8'h23);
        chk("model next 23", tbnext(8'h23), 8'h47);

        repeat (2) @(posedge clk);
        #1;
        chk("reset locked", locked_a, 0);
        chk("reset error", error_a, 0);
        chk("reset count", err_count_a, 0);
        chk("reset state", state_dbg_a, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Acquisition from seed 01.
        gen = 8'h01;
        drive(gen, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) good(1'b0);
        chk("acq pre-lock", locked_a, 0);
        good(1'b0);
        chk("acq lock word", gen, 8'h11);
        chk("acq locked", locked_a, 1);
        chk("acq count", err_count_a, 0);
        good(1'b0);
        chk("acq 23 no err", error_a, 0);

        // Single error then correct word.
        bad(1'b0);
        chk("single err pulse", error_a, 1);
        chk("single err count", err_count_a, 1);
        chk("single err locked", locked_a, 1);
        good(1'b0);
        chk("after err no pulse", error_a, 0);

        // Loss of lock with three zero words, then reacquire.
        good(1'b1);
        for (int i = 0; i < 3; i++) begin
            gen = tbnext(gen);
            drive(8'h00, 1'b1, 1'b0);
            chk("loss err pulse", error_a, 1);
        end
        chk("loss count", err_count_a, 3);
        chk("loss locked", locked_a, 0);
        chk("loss state", state_dbg_a, 2);
        gen = 8'hC3;
        drive(gen, 1'b1, 1'b0);
        chk("reseed state", state_dbg_a, 0);
        for (int i = 0; i < 3; i++) good(1'b0);
        chk("relock pre", locked_a, 0);
        good(1'b0);
        chk("relock", locked_a, 1);

        // Saturation of the 4-bit counter, then clear during a mismatch.
        good(1'b1);
        for (int i = 0; i < 20; i++) begin
            bad(1'b0);
            good(1'b0);
        end
        chk("sat count4", err_count_b, 15);
        chk("sat count16", err_count_a, 20);
        chk("sat locked", locked_a, 1);
        bad(1'b1);
        chk("clear err pulse", error_b, 1);
        chk("clear count4", err_count_b, 0);
        chk("clear count16", err_count_a, 0);

        // Mid-operation asynchronous reset with five errors counted.
        good(1'b1);
        for (int i = 0; i < 5; i++) begin
            bad(1'b0);
            good(1'b0);
        end
        chk("pre-reset count", err_count_a, 5);
        bad(1'b0);
        chk("pre-reset error", error_a, 1);
        #2 reset = 1'b1;
        #1;
        chk("async locked", locked_a, 0);
        chk("async error", error_a, 0);
        chk("async count", err_count_a, 0);
        chk("async state", state_dbg_a, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // All-zero words never lock.
        for (int i = 0; i < 12; i++) drive(8'h00, 1'b1, 1'b0);
        chk("zeros no lock", locked_a, 0);

        // Acquisition with valid gaps: lock timing counts valid words only.
        gen = 8'h5A;
        drive(gen, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            repeat ($urandom_range(0, 3)) drive(8'hFF, 1'b0, 1'b0);
            chk("gap pre-lock", locked_a, 0);
            good(1'b0);
        end
        chk("gap locked", locked_a, 1);

        // Random mix of correct, corrupted, zero and reseeded words.
        for (int i = 0; i < 3000; i++) begin
            int r;
            logic v, c;
            r = int'($urandom_range(0, 99));
            v = ($urandom_range(0, 99) < 80);
            c = ($urandom_range(0, 99) < 2);
            if (!v) drive(8'($urandom), 1'b0, c);
            else if (r < 75) good(c);
            else if (r < 87) begin gen = tbnext(gen); drive(8'($urandom), 1'b1, c); end
            else if (r < 94) begin gen = tbnext(gen); drive(8'h00, 1'b1, c); end
            else begin gen = 8'($urandom_range(1, 255)); drive(gen, 1'b1, c); end
        end

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
